first_system_decoder: RTL and testbench

- Receive-side inverse of the team's two-wire dataflow encoder, which drives enc1 = in1 XOR in2 and enc2 = NOT in2.
- Accepts a stream of encoded pairs (enc1, enc2) over a valid/ready handshake and recovers the original (in1, in2) pairs.
- Packs PAIRS recovered pairs into one word and presents it on a valid/ready output with backpressure.
- Sits between the encoded link and downstream word-wide logic.

---
 rtl/first_system_decoder.sv | 114 +++++++++++
 tb/tb_first_system_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/first_system_decoder.sv
// Receive-side decoder for the two-wire dataflow link: recovers (in1, in2) pairs and packs PAIRS
// of them per output word. Define FIRST_SYSTEM_DECODER_STATS_EN to add a saturating word counter.
module first_system_decoder #(
  parameter int unsigned PAIRS = 4,
  parameter int unsigned CW    = $clog2(PAIRS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_valid,
  input  logic                 enc1,
  input  logic                 enc2,
  output logic                 enc_ready,
  input  logic                 flush,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [2*PAIRS-1:0]   word_data,
  output logic [CW-1:0]        word_pairs
`ifdef FIRST_SYSTEM_DECODER_STATS_EN
  ,
  output logic [15:0]          word_count
`endif
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      pairs_q, pairs_d;
  logic [2*PAIRS-1:0] data_q, data_d;
  logic               accept;
  logic [1:0]         pair;

  // Gated by rst_n so the link sees no ready while reset is asserted.
  assign enc_ready  = rst_n & ((state_q == StCollect) | word_ready);
  assign accept     = enc_valid & enc_ready;
  assign pair       = {enc1 ^ ~enc2, ~enc2};
  assign word_valid = (state_q == StHold);
  assign word_data  = data_q;
  assign word_pairs = pairs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pairs_d = pairs_q;
    data_d  = data_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          for (int unsigned k = 0; k < PAIRS; k++) begin
            if (cnt_q == CW'(k)) data_d[2*k +: 2] = pair;
          end
          cnt_d = cnt_q + CW'(1);
        end
        if (accept && (cnt_q == CW'(PAIRS - 1))) begin
          state_d = StHold;
          pairs_d = CW'(PAIRS);
          cnt_d   = '0;
        end else if (flush && ((cnt_q != '0) || accept)) begin
          state_d = StHold;
          pairs_d = cnt_q + CW'(accept);
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (word_ready) begin
          state_d = StCollect;
          data_d  = '0;
          pairs_d = '0;
          cnt_d   = '0;
          // A pair accepted on the handshake cycle starts the next word in slot 0.
          if (accept) begin
            data_d[1:0] = pair;
            if (PAIRS == 1) begin
              state_d = StHold;
              pairs_d = CW'(1);
            end else begin
              cnt_d = CW'(1);
            end
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      pairs_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pairs_q <= pairs_d;
      data_q  <= data_d;
    end
  end

`ifdef FIRST_SYSTEM_DECODER_STATS_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
    end else if (word_valid && word_ready && (word_count_q != 16'hFFFF)) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_first_system_decoder.sv
// Table-driven bench for first_system_decoder (PAIRS = 4) plus reset and counter sequences.
module tb_first_system_decoder;

  localparam int unsigned PAIRS = 4;
  localparam int unsigned CW    = $clog2(PAIRS + 1);

  logic             clk, rst_n;
  logic             enc_valid, enc1, enc2, flush, word_ready;
  logic             enc_ready, word_valid;
  logic [2*PAIRS-1:0] word_data;
  logic [CW-1:0]    word_pairs;
`ifdef FIRST_SYSTEM_DECODER_STATS_EN
  logic [15:0]      word_count;
`endif

  first_system_decoder #(.PAIRS(PAIRS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_valid  (enc_valid),
    .enc1       (enc1),
    .enc2       (enc2),
    .enc_ready  (enc_ready),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_pairs (word_pairs)
`ifdef FIRST_SYSTEM_DECODER_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, e1, e2, f, wr;
    logic       er, wv;
    logic [7:0] data;
    logic [2:0] pairs;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic v, e1, e2, f, wr, er, wv, input logic [7:0] data,
                     input logic [2:0] pairs);
    vec_t t;
    t.v = v; t.e1 = e1; t.e2 = e2; t.f = f; t.wr = wr;
    t.er = er; t.wv = wv; t.data = data; t.pairs = pairs;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, e1, e2, f, wr);
    enc_valid = v; enc1 = e1; enc2 = e2; flush = f; word_ready = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // columns: valid enc1 enc2 flush word_ready | enc_ready word_valid word_data word_pairs
    // full word, word_ready high
    add(1, 1, 0, 0, 1, 1, 0, 8'h00, 0);
    add(1, 0, 0, 0, 1, 1, 0, 8'h01, 0);
    add(1, 1, 1, 0, 1, 1, 0, 8'h0D, 0);
    add(1, 0, 1, 0, 1, 1, 0, 8'h2D, 0);
    add(0, 0, 0, 0, 1, 1, 1, 8'h2D, 4);
    add(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    // backpressure
    add(1, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    add(1, 0, 0, 0, 0, 1, 0, 8'h01, 0);
    add(1, 1, 1, 0, 0, 1, 0, 8'h0D, 0);
    add(1, 0, 1, 0, 0, 1, 0, 8'h2D, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, (i == 2), 0, 0, 1, 8'h2D, 4);
    add(1, 1, 1, 0, 1, 1, 1, 8'h2D, 4);
    add(0, 0, 0, 1, 0, 1, 0, 8'h02, 0);
    add(0, 0, 0, 0, 1, 1, 1, 8'h02, 1);
    // flush partial, then flush on empty
    add(1, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    add(1, 0, 0, 0, 0, 1, 0, 8'h01, 0);
    add(0, 0, 0, 1, 0, 1, 0, 8'h0D, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h0D, 2);
    add(0, 0, 0, 0, 1, 1, 1, 8'h0D, 2);
    add(0, 0, 0, 1, 0, 1, 0, 8'h00, 0);
    add(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    // flush with simultaneous accept
    add(1, 1, 0, 0, 0, 1, 0, 8'h00, 0);
    add(1, 1, 1, 1, 0, 1, 0, 8'h01, 0);
    add(0, 0, 0, 0, 1, 1, 1, 8'h09, 2);
    add(0, 0, 0, 0, 1, 1, 0, 8'h00, 0);
    // back-to-back words, no bubble at the boundary
    add(1, 0, 0, 0, 1, 1, 0, 8'h00, 0);
    add(1, 0, 0, 0, 1, 1, 0, 8'h03, 0);
    add(1, 0, 0, 0, 1, 1, 0, 8'h0F, 0);
    add(1, 0, 0, 0, 1, 1, 0, 8'h3F, 0);
    add(1, 1, 0, 0, 1, 1, 1, 8'hFF, 4);
    add(1, 1, 0, 0, 1, 1, 0, 8'h01, 0);
    add(0, 0, 0, 0, 1, 1, 0, 8'h05, 0);

    // reset with enc_valid asserted
    rst_n = 1'b0;
    drive(1, 1, 0, 0, 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_enc_ready", 32'(enc_ready), 0);
      chk("rst_word_valid", 32'(word_valid), 0);
      chk("rst_word_data", 32'(word_data), 0);
      chk("rst_word_pairs", 32'(word_pairs), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_enc_ready", 32'(enc_ready), 1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].e1, vecs[i].e2, vecs[i].f, vecs[i].wr);
      #1;
      chk($sformatf("v%0d_enc_ready", i), 32'(enc_ready), 32'(vecs[i].er));
      chk($sformatf("v%0d_word_valid", i), 32'(word_valid), 32'(vecs[i].wv));
      chk($sformatf("v%0d_word_data", i), 32'(word_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_word_pairs", i), 32'(word_pairs), 32'(vecs[i].pairs));
      tick();
    end

`ifdef FIRST_SYSTEM_DECODER_STATS_EN
    chk("word_count_6", 32'(word_count), 6);
`endif

    // reset mid-word: two pairs are stored, reset must drop them
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_word_data", 32'(word_data), 0);
    chk("midrst_enc_ready", 32'(enc_ready), 0);
`ifdef FIRST_SYSTEM_DECODER_STATS_EN
    chk("midrst_word_count", 32'(word_count), 0);
`endif
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    chk("midrst_no_word", 32'(word_valid), 0);
    chk("midrst_pairs", 32'(word_pairs), 0);

`ifdef FIRST_SYSTEM_DECODER_STATS_EN
    // three full words, then saturation
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1, 0, 1, 0, 1);
        tick();
      end
      drive(0, 0, 0, 0, 1);
      tick();
    end
    #1;
    chk("word_count_3", 32'(word_count), 3);
    force dut.word_count_q = 16'hFFFF;
    #1;
    release dut.word_count_q;
    drive(1, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    chk("sat_hs_valid", 32'(word_valid), 1);
    tick();
    chk("word_count_sat", 32'(word_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
